pipeline_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage MIPS core.
- Drives the EN/flush controls and PC enable consumed by IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers.
- Resolves these events from hit/hazard/redirect/halt inputs:
  - data-memory wait freeze
  - load-use stall
  - branch/jump squash
  - I-fetch bubbles
  - sticky halt
- Sits beside the datapath and feeds every pipe register's flush/EN pair.

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/hazard_detect.sv | 18 +
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller and its hazard unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between EX and ID; also reused by the forwarding unit.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign load_use = ex_dREN && (ex_wsel != REG_W'(REG_ZERO)) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/enable controller for the 5-stage pipeline.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
//
// state  | meaning
// RUN    | normal issue; hazards resolved combinationally
// DWAIT  | data memory access outstanding, pipeline frozen until dhit
// HALTED | halt retired; everything held until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state;
    logic        mem_busy;
    logic        load_use;

    assign mem_busy = (mem_dREN || mem_dWEN) && !dhit;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_dREN  (ex_dREN),
        .ex_wsel  (ex_wsel),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .load_use (load_use)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (wb_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (mem_busy) begin
                        state <= DWAIT;
                    end
                end
                DWAIT: begin
                    if (wb_halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (dhit) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    // A frozen EX keeps ex_redirect asserted, so freezing ahead of a redirect loses nothing.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if ((state == HALTED) || wb_halt || mem_busy) begin
            pc_en = 1'b0;
        end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (!ihit) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

`ifdef PIPE_PERF_EN
    logic             any_flush;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign any_flush = ifid_flush || idex_flush || exmem_flush || memwb_flush;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (state != HALTED) cyc_q <= cyc_q + 1'b1;
            if ((state != HALTED) && !pc_en) stall_q <= stall_q + 1'b1;
            if (any_flush) flush_q <= flush_q + 1'b1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + random bench for pipeline_ctrl with a reference model and expected-result queue.
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RW = 5;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_redirect, wb_halt;
    logic [RW-1:0] ex_wsel, id_rs, id_rt;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [CW-1:0] cyc_cnt, stall_cnt, flush_cnt;

    pipeline_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    int            n_assert = 0;
    int            n_fail   = 0;
    bit            chk_en   = 1'b0;
    ctrl_state_t   m_st     = RUN;
    logic [CW-1:0] m_cyc = '0, m_stall = '0, m_flush = '0;
    logic [9:0]    exp_q[$];

    // bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush
    localparam logic [8:0] O_NONE = 9'b0_00_00_00_00;
    localparam logic [8:0] O_NORM = 9'b1_10_10_10_10;
    localparam logic [8:0] O_REDR = 9'b1_01_01_10_10;
    localparam logic [8:0] O_LDUS = 9'b0_00_01_10_10;
    localparam logic [8:0] O_IMIS = 9'b0_01_10_10_10;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_busy();
        return (mem_dREN | mem_dWEN) & ~dhit;
    endfunction

    function automatic logic [8:0] model_out();
        logic lu;
        lu = ex_dREN && (ex_wsel != 0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
        if (m_st == HALTED || wb_halt) return O_NONE;
        if (m_busy())                  return O_NONE;
        if (ex_redirect)               return O_REDR;
        if (lu)                        return O_LDUS;
        if (!ihit)                     return O_IMIS;
        return O_NORM;
    endfunction

    function automatic logic [8:0] dut_out();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, memwb_flush};
    endfunction

    // One cycle: inputs already driven; push expectation, compare mid-cycle, advance model at the edge.
    task automatic cyc(input string tag);
        logic [8:0] e;
        logic [9:0] ev;
        e = model_out();
        exp_q.push_back({m_st == HALTED, e});
        @(negedge CLK);
        ev = exp_q.pop_front();
        if (chk_en) begin
            chk({tag, "_outs"}, {22'd0, halted, dut_out()}, {22'd0, ev});
`ifdef PIPE_PERF_EN
            chk({tag, "_cyc"},   {28'd0, cyc_cnt},   {28'd0, m_cyc});
            chk({tag, "_stall"}, {28'd0, stall_cnt}, {28'd0, m_stall});
            chk({tag, "_flush"}, {28'd0, flush_cnt}, {28'd0, m_flush});
`else
            chk({tag, "_cnt0"}, {20'd0, cyc_cnt, stall_cnt, flush_cnt}, 32'd0);
`endif
        end
        @(posedge CLK);
        if (!nRST) begin
            m_st = RUN; m_cyc = '0; m_stall = '0; m_flush = '0;
        end else begin
            if (m_st != HALTED) m_cyc = m_cyc + 1'b1;
            if (m_st != HALTED && !e[8]) m_stall = m_stall + 1'b1;
            if (e[6] | e[4] | e[2] | e[0]) m_flush = m_flush + 1'b1;
            case (m_st)
                RUN:     if (wb_halt) m_st = HALTED; else if (m_busy()) m_st = DWAIT;
                DWAIT:   if (wb_halt) m_st = HALTED; else if (dhit) m_st = RUN;
                default: m_st = HALTED;
            endcase
        end
        #1;
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
        ex_redirect = 1'b0; wb_halt = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
    endtask

    initial begin
        idle();
        ihit = 1'b0;
        nRST = 1'b0;
        cyc("rst_pre");
        chk_en = 1'b1;
        cyc("rst");
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_imiss", {23'd0, dut_out()}, {23'd0, O_IMIS});

        // Plain run
        nRST = 1'b1; idle();
        for (int i = 0; i < 3; i++) cyc("t1_run");
        chk("t1_norm", {23'd0, dut_out()}, {23'd0, O_NORM});
`ifdef PIPE_PERF_EN
        chk("t1_cyc3", {28'd0, cyc_cnt}, 32'd3);
`endif

        // Load-use stall, then $zero destination and rs match
        ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8;
        cyc("t2_lu");
        ex_wsel = 5'd0; id_rt = 5'd0;
        cyc("t2_zero");
        ex_wsel = 5'd9; id_rs = 5'd9; id_rt = 5'd3;
        cyc("t2_rs");
        idle();

        // Data-memory wait
        mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) cyc("t3_frz");
        dhit = 1'b1;
        cyc("t3_dhit");
        idle();
        cyc("t3_after");

        // Redirect beats load-use and ihit miss; freeze beats redirect
        ex_redirect = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; ihit = 1'b0;
        cyc("t4_redir");
        mem_dWEN = 1'b1;
        cyc("t4_frz");
        dhit = 1'b1;
        cyc("t4_unfrz");
        idle();

        // Counter wrap and flush count
        nRST = 1'b0;
        cyc("t6_rst");
        nRST = 1'b1;
        for (int i = 0; i < 17; i++) cyc("t6_run");
`ifdef PIPE_PERF_EN
        chk("t6_wrap", {28'd0, cyc_cnt}, 32'd1);
`endif
        ex_redirect = 1'b1;
        cyc("t6_r1");
        cyc("t6_r2");
        idle();
        cyc("t6_idle");
`ifdef PIPE_PERF_EN
        chk("t6_flush2", {28'd0, flush_cnt}, 32'd2);
`endif

        // Sticky halt and recovery through reset
        wb_halt = 1'b1;
        cyc("t5_halt");
        wb_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ihit = i[0]; ex_redirect = i[1]; mem_dREN = i[2];
            cyc("t5_hold");
        end
        chk("t5_sticky", {31'd0, halted}, 32'd1);
        idle();
        nRST = 1'b0;
        cyc("t5_rst");
        nRST = 1'b1;
        chk("t5_clr", {31'd0, halted}, 32'd0);
        cyc("t5_run");

        // Random mix
        for (int i = 0; i < 300; i++) begin
            nRST        = ($urandom_range(0, 29) != 0);
            ihit        = ($urandom_range(0, 3) != 0);
            dhit        = ($urandom_range(0, 2) == 0);
            mem_dREN    = ($urandom_range(0, 3) == 0);
            mem_dWEN    = ($urandom_range(0, 5) == 0);
            ex_dREN     = ($urandom_range(0, 1) == 0);
            ex_redirect = ($urandom_range(0, 4) == 0);
            wb_halt     = ($urandom_range(0, 39) == 0);
            ex_wsel     = RW'($urandom_range(0, 3));
            id_rs       = RW'($urandom_range(0, 3));
            id_rt       = RW'($urandom_range(0, 3));
            cyc("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
